// File: rtl/bus_arbiter.sv
// Shares one memory bus between the 6502 CPU wrapper and a DMA master, inserting
// fixed wait states and capping DMA bursts so the CPU always gets a slot.
module bus_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int WAIT_STATES = 1,
    parameter int MAX_BURST   = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_dat,
    input  logic          i_cpu_we,
    output logic [DW-1:0] o_cpu_dat,
    output logic          o_cpu_active,
    output logic          o_cpu_ack,
    input  logic          i_dma_req,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [DW-1:0] i_dma_dat,
    input  logic          i_dma_we,
    output logic [DW-1:0] o_dma_dat,
    output logic          o_dma_ack,
    output logic          o_dma_grant,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_dat,
    output logic          o_mem_we,
    output logic          o_mem_stb,
    input  logic [DW-1:0] i_mem_dat
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam logic [3:0] WS_LAST       = 4'(WAIT_STATES);
    localparam logic [7:0] BURST_LAST    = 8'(MAX_BURST - 1);
    localparam logic       LAST_AT_START = (WAIT_STATES == 0);

    owner_t     owner_reg;
    logic [3:0] wcnt_reg;
    logic [7:0] bcnt_reg;
    // Registered decode of wcnt_reg == WS_LAST, i.e. this is the final cycle of the access
    logic       last_reg;
    logic       cpu_own;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            owner_reg <= OWN_CPU;
            wcnt_reg  <= 4'd0;
            bcnt_reg  <= 8'd0;
            last_reg  <= LAST_AT_START;
        end else begin
            case (owner_reg)
                OWN_CPU: begin
                    if (last_reg) begin
                        wcnt_reg <= 4'd0;
                        last_reg <= LAST_AT_START;
                        if (i_dma_req) begin
                            owner_reg <= OWN_DMA;
                            bcnt_reg  <= 8'd0;
                        end
                    end else begin
                        wcnt_reg <= wcnt_reg + 4'd1;
                        last_reg <= ((wcnt_reg + 4'd1) == WS_LAST);
                    end
                end
                OWN_DMA: begin
                    // A request withdrawn mid-access abandons it without an ack
                    if (!i_dma_req) begin
                        owner_reg <= OWN_CPU;
                        wcnt_reg  <= 4'd0;
                        last_reg  <= LAST_AT_START;
                    end else if (last_reg) begin
                        wcnt_reg <= 4'd0;
                        last_reg <= LAST_AT_START;
                        bcnt_reg <= bcnt_reg + 8'd1;
                        if (bcnt_reg == BURST_LAST) begin
                            owner_reg <= OWN_CPU;
                        end
                    end else begin
                        wcnt_reg <= wcnt_reg + 4'd1;
                        last_reg <= ((wcnt_reg + 4'd1) == WS_LAST);
                    end
                end
                default: begin
                    owner_reg <= OWN_CPU;
                    wcnt_reg  <= 4'd0;
                    last_reg  <= LAST_AT_START;
                end
            endcase
        end
    end

    assign cpu_own = (owner_reg == OWN_CPU);

    // Control outputs are gated by reset so an asserted reset silences the bus at once
    assign o_cpu_active = i_reset_n & cpu_own;
    assign o_cpu_ack    = i_reset_n & cpu_own & last_reg;
    assign o_dma_grant  = i_reset_n & ~cpu_own;
    assign o_dma_ack    = i_reset_n & ~cpu_own & last_reg & i_dma_req;
    assign o_mem_stb    = i_reset_n;
    assign o_mem_we     = i_reset_n & (cpu_own ? i_cpu_we : i_dma_we);

    assign o_mem_addr = cpu_own ? i_cpu_addr : i_dma_addr;
    assign o_mem_dat  = cpu_own ? i_cpu_dat : i_dma_dat;
    assign o_cpu_dat  = i_mem_dat;
    assign o_dma_dat  = i_mem_dat;

endmodule

// File: tb/tb_bus_arbiter.sv
// Two arbiters (1 wait state / burst 4, and 0 wait states / burst 2) driven by
// directed and random CPU/DMA traffic and compared cycle by cycle with an access-level model.
module tb_bus_arbiter;

    localparam int N = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr  [N];
    logic [7:0]  cpu_wdat  [N];
    logic        cpu_we    [N];
    logic [7:0]  cpu_rdat  [N];
    logic        cpu_active[N];
    logic        cpu_ack   [N];
    logic        dma_req   [N];
    logic [15:0] dma_addr  [N];
    logic [7:0]  dma_wdat  [N];
    logic        dma_we    [N];
    logic [7:0]  dma_rdat  [N];
    logic        dma_ack   [N];
    logic        dma_grant [N];
    logic [15:0] mem_addr  [N];
    logic [7:0]  mem_wdat  [N];
    logic        mem_we    [N];
    logic        mem_stb   [N];
    logic [7:0]  mem_rdat  [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            bus_arbiter #(
                .AW(16), .DW(8),
                .WAIT_STATES(gi == 0 ? 1 : 0),
                .MAX_BURST(gi == 0 ? 4 : 2)
            ) u_dut (
                .i_clk(clk), .i_reset_n(rst_n),
                .i_cpu_addr(cpu_addr[gi]), .i_cpu_dat(cpu_wdat[gi]), .i_cpu_we(cpu_we[gi]),
                .o_cpu_dat(cpu_rdat[gi]), .o_cpu_active(cpu_active[gi]), .o_cpu_ack(cpu_ack[gi]),
                .i_dma_req(dma_req[gi]), .i_dma_addr(dma_addr[gi]), .i_dma_dat(dma_wdat[gi]),
                .i_dma_we(dma_we[gi]), .o_dma_dat(dma_rdat[gi]), .o_dma_ack(dma_ack[gi]),
                .o_dma_grant(dma_grant[gi]), .o_mem_addr(mem_addr[gi]), .o_mem_dat(mem_wdat[gi]),
                .o_mem_we(mem_we[gi]), .o_mem_stb(mem_stb[gi]), .i_mem_dat(mem_rdat[gi])
            );
            // Memory returns the low address byte
            assign mem_rdat[gi] = mem_addr[gi][7:0];
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Access-level model: current owner, cycles left in the access, DMA accesses done in burst
    bit m_dma   [N];
    int m_left  [N];
    int m_burst [N];
    bit ack_prev[N];

    // DMA agent: 0 idle, 1 single write, 2 continuous, 3 random, 4 drop in first cycle
    int mode[N];
    bit pend[N];
    bit shot[N];

    function automatic int ws_of(int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int mb_of(int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic chk(string tag, int k, logic [47:0] got, logic [47:0] exp);
        n_total = n_total + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s dut%0d @%0t observed=%h expected=%h", tag, k, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_dma[k]    = 1'b0;
            m_left[k]   = ws_of(k);
            m_burst[k]  = 0;
            ack_prev[k] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            logic        last;
            logic [5:0]  e_ctl, g_ctl;
            logic [15:0] e_addr;
            logic [7:0]  e_wdat;
            last = (m_left[k] == 0);
            if (rst_n)
                e_ctl = {!m_dma[k], !m_dma[k] && last, m_dma[k], m_dma[k] && dma_req[k] && last,
                         1'b1, m_dma[k] ? dma_we[k] : cpu_we[k]};
            else
                e_ctl = 6'b0;
            g_ctl = {cpu_active[k], cpu_ack[k], dma_grant[k], dma_ack[k], mem_stb[k], mem_we[k]};
            chk("ctl{act,cack,grant,dack,stb,we}", k, 48'(g_ctl), 48'(e_ctl));
            if (rst_n) begin
                e_addr = m_dma[k] ? dma_addr[k] : cpu_addr[k];
                e_wdat = m_dma[k] ? dma_wdat[k] : cpu_wdat[k];
                chk("bus{addr,wdat,crd,drd}", k,
                    48'({mem_addr[k], mem_wdat[k], cpu_rdat[k], dma_rdat[k]}),
                    48'({e_addr, e_wdat, e_addr[7:0], e_addr[7:0]}));
            end
        end
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            ack_prev[k] = rst_n && m_dma[k] && dma_req[k] && (m_left[k] == 0);
            if (ack_prev[k])
                $display("dut%0d dma %s addr=%h dat=%h burst=%0d", k, dma_we[k] ? "write" : "read",
                         dma_addr[k], dma_we[k] ? dma_wdat[k] : dma_addr[k][7:0], m_burst[k] + 1);
            if (!rst_n) begin
                m_dma[k]   = 1'b0;
                m_left[k]  = ws_of(k);
                m_burst[k] = 0;
            end else if (m_dma[k] && !dma_req[k]) begin
                m_dma[k]  = 1'b0;
                m_left[k] = ws_of(k);
            end else if (m_left[k] == 0) begin
                m_left[k] = ws_of(k);
                if (!m_dma[k]) begin
                    if (dma_req[k]) begin
                        m_dma[k]   = 1'b1;
                        m_burst[k] = 0;
                    end
                end else begin
                    m_burst[k] = m_burst[k] + 1;
                    if (m_burst[k] == mb_of(k)) m_dma[k] = 1'b0;
                end
            end else begin
                m_left[k] = m_left[k] - 1;
            end
        end
    endtask

    task automatic start_req(int k, logic [15:0] a, logic [7:0] d, logic w);
        pend[k]     = 1'b1;
        dma_addr[k] = a;
        dma_wdat[k] = d;
        dma_we[k]   = w;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            cpu_addr[k] = 16'($urandom);
            cpu_wdat[k] = 8'($urandom);
            cpu_we[k]   = 1'($urandom);
            if (pend[k] && ack_prev[k]) pend[k] = 1'b0;
            case (mode[k])
                1: if (!pend[k] && shot[k]) begin
                       shot[k] = 1'b0;
                       start_req(k, 16'h1234, 8'h5A, 1'b1);
                   end
                2: if (!pend[k]) start_req(k, 16'($urandom), 8'($urandom), 1'($urandom));
                3: if (!pend[k] && ($urandom_range(0, 1) == 1))
                       start_req(k, 16'($urandom), 8'($urandom), 1'($urandom));
                4: if (!pend[k] && shot[k]) begin
                       shot[k] = 1'b0;
                       start_req(k, 16'($urandom), 8'($urandom), 1'b1);
                   end else if (pend[k] && m_dma[k] && (m_left[k] == ws_of(k))) begin
                       pend[k] = 1'b0;
                   end
                default: ;
            endcase
            dma_req[k] = pend[k];
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic set_mode(int m);
        for (int k = 0; k < N; k++) begin
            mode[k] = m;
            shot[k] = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            dma_req[k] = 1'b0;
            dma_addr[k] = '0;
            dma_wdat[k] = '0;
            dma_we[k] = 1'b0;
        end
        set_mode(0);
        model_reset();
        @(negedge clk);
        run(2);
        rst_n = 1'b1;

        run(20);                 // CPU only
        run(1);
        set_mode(1); run(12);    // single DMA write to 0x1234, raised mid CPU access
        set_mode(2); run(30);    // continuous DMA requests hit the burst limit
        set_mode(3); run(150);   // random DMA traffic
        set_mode(0); run(6);
        set_mode(4); run(12);    // request withdrawn before its ack

        // Asynchronous reset in the middle of a DMA access
        set_mode(2);
        for (int i = 0; i < 20 && !m_dma[0]; i++) cycle();
        drive();
        #1;
        check_all();
        chk("pre_reset_grant", 0, 48'(dma_grant[0]), 48'd1);
        #2;
        rst_n = 1'b0;
        #1;
        set_mode(0);
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        model_reset();
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
        run(1);
        rst_n = 1'b1;
        run(20);
        set_mode(3); run(100);
        set_mode(0); run(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sits directly downstream of the asynchronous-bus 6502 CPU wrapper.
- Consumes the CPU's combinational address, write data and write enable, and shares one memory bus between the CPU and a DMA master.
- Generates the CPU's `active` (bus owned) and `ack` (access complete) inputs. The CPU stalls unless both are high.
- Inserts a fixed number of memory wait states.
- Bounds DMA bursts so the CPU is never starved.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- WAIT_STATES, 1, extra cycles per memory access (access length = WAIT_STATES+1 cycles); legal range 0..15.
- MAX_BURST, 4, maximum consecutive DMA accesses before one CPU access is forced; legal range 1..255.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_cpu_addr  in  AW  CPU address (combinational from core).
- i_cpu_dat  in  DW  CPU write data.
- i_cpu_we  in  1  CPU write enable.
- o_cpu_dat  out  DW  read data to CPU; equals i_mem_dat.
- o_cpu_active  out  1  CPU owns bus this cycle.
- o_cpu_ack  out  1  CPU access completes this cycle.
- i_dma_req  in  1  DMA access request; held until o_dma_ack.
- i_dma_addr  in  AW  DMA address, stable while i_dma_req.
- i_dma_dat  in  DW  DMA write data.
- i_dma_we  in  1  DMA write enable.
- o_dma_dat  out  DW  read data to DMA; equals i_mem_dat, valid in the o_dma_ack cycle.
- o_dma_ack  out  1  one-cycle pulse, DMA access complete.
- o_dma_grant  out  1  DMA owns bus.
- o_mem_addr  out  AW  memory address, muxed from owner.
- o_mem_dat  out  DW  memory write data, muxed from owner.
- o_mem_we  out  1  memory write enable; only with o_mem_stb.
- o_mem_stb  out  1  memory access strobe.
- i_mem_dat  in  DW  memory read data, combinational, valid in last cycle of an access.

Behaviour:
- State: owner FSM {CPU, DMA}, wait counter wcnt (4 b), burst counter bcnt (8 b).
- Reset: owner=CPU, wcnt=0, bcnt=0.
- While i_reset_n=0, o_mem_stb, o_mem_we, o_cpu_active, o_cpu_ack, o_dma_ack and o_dma_grant are forced 0 combinationally.
- Release of reset is not synchronised here; reset is synchronised upstream.

CPU state:
- o_cpu_active=1, o_dma_grant=0, o_mem_stb=1.
- o_mem_addr, o_mem_dat and o_mem_we are taken from the CPU.
- wcnt increments each cycle. In the cycle where wcnt==WAIT_STATES: o_cpu_ack=1 and wcnt→0 (the access boundary).
- At the boundary, if i_dma_req=1, next state is DMA with bcnt=0. Otherwise stay in CPU.
- WAIT_STATES=0 gives ack every cycle.

DMA state:
- o_cpu_active=0, o_cpu_ack=0, o_dma_grant=1, o_mem_stb=1.
- Memory outputs are taken from the DMA.
- wcnt counts as in the CPU state. At wcnt==WAIT_STATES: o_dma_ack=1, wcnt→0, bcnt+1.
- After the ack:
  - If bcnt+1==MAX_BURST, or i_dma_req is low in the next cycle's decision, go to CPU.
  - Otherwise stay in DMA for the next access.
- Decision rule: DMA that keeps i_dma_req high after an ack is treated as a new request and is sampled at the ack edge.
- If i_dma_req drops before ack (protocol violation):
  - Next cycle returns to CPU with wcnt=0.
  - No o_dma_ack is issued.
  - The memory write may have been partially strobed; this is undefined for memory.

Forced CPU slot:
- After a burst limit, the CPU gets exactly one full access, even if i_dma_req=1.
- Ownership only changes at access boundaries. A started access is never pre-empted.

Other rules:
- Latency: DMA request seen in a CPU access completes at the earliest (WAIT_STATES+1)·2 cycles after the CPU access start.
- Read data paths are pure combinational pass-through. The owner latches on its ack edge.
- Counters never wrap. wcnt is bounded by WAIT_STATES; bcnt is cleared on entering DMA.
- Async reset mid-access aborts immediately. No ack is issued for the aborted access.

Test Plan:
- CPU only, WAIT_STATES=1, 10 reads, memory returns addr[7:0] → o_cpu_active constantly 1, o_cpu_ack toggles 0,1,0,1…, o_cpu_dat captured = addr low byte each ack.
- DMA single write to 0x1234, data 0x5A, requested mid-CPU access → CPU access completes first, then 2 cycles of o_mem_addr=0x1234, o_mem_we=1, one o_dma_ack, then back to CPU with o_cpu_active=1.
- DMA req held continuously, MAX_BURST=4 → pattern of 4 DMA acks, 1 CPU ack, 4 DMA acks; o_cpu_active low throughout each DMA run.
- WAIT_STATES=0, DMA req pulses every other access → alternating single-cycle owners, no cycle with both acks, o_mem_stb constantly 1.
- DMA drops i_dma_req in the first wait cycle → no o_dma_ack, next cycle o_cpu_active=1, wcnt restarted (CPU ack 2 cycles later).
- Assert i_reset_n=0 asynchronously mid-DMA access → o_mem_stb, o_dma_ack and o_dma_grant go 0 immediately. After release, the CPU owns the bus and the first o_cpu_ack comes after WAIT_STATES+1 cycles.
